// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front-end pipeline registers.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned ALUCTL_W         = 3;
  localparam int unsigned REG_ADDR_W       = 5;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Execute-stage control bundle carried through ID/EX.
  typedef struct packed {
    logic                regWrite;
    logic                memtoReg;
    logic                memWrite;
    logic                aluSrc;
    logic                regDst;
    logic [ALUCTL_W-1:0] aluControl;
  } ctrlE_t;

  // IF/ID payload; an all-zero value is a NOP bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } ifId_t;

  // ID/EX payload; an all-zero value is a bubble that writes nothing.
  typedef struct packed {
    logic                  valid;
    ctrlE_t                ctrl;
    logic [31:0]           rd1;
    logic [31:0]           rd2;
    logic [31:0]           signImm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } idEx_t;

endpackage

// File: rtl/pipe_flop_enclr.sv
// Generic pipeline register: async active-low reset, enable, synchronous clear.
// Clear only takes effect on enabled cycles, so a held stage keeps its contents.
module pipe_flop_enclr #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: hold when disabled, zero on clear, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      if (clr) q <= '0;
      else     q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Front-end pipeline register bank: PC, IF/ID and ID/EX registers with
// stall/flush handling, stall and bubble counters and a stall watchdog.
module pipe_ctrl_regs
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MAX_STALL = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           PCNextF,
  input  logic [31:0]           InstrF,
  input  logic [31:0]           PCPlus4F,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  FlushE,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  ALUSrcD,
  input  logic                  RegDstD,
  input  logic [ALUCTL_W-1:0]   ALUControlD,
  input  logic [31:0]           RD1D,
  input  logic [31:0]           RD2D,
  input  logic [31:0]           SignImmD,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  CntClr,
  output logic [31:0]           PCF,
  output logic [31:0]           InstrD,
  output logic [31:0]           PCPlus4D,
  output logic                  ValidD,
  output logic                  RegWriteE,
  output logic                  MemtoRegE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  RegDstE,
  output logic [ALUCTL_W-1:0]   ALUControlE,
  output logic [31:0]           RD1E,
  output logic [31:0]           RD2E,
  output logic [31:0]           SignImmE,
  output logic [REG_ADDR_W-1:0] RsE,
  output logic [REG_ADDR_W-1:0] RtE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic                  ValidE,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      BubbleCount,
  output logic                  StallTimeout
);

  localparam int unsigned IfIdW    = $bits(ifId_t);
  localparam int unsigned IdExW    = $bits(idEx_t);
  localparam logic [8:0]  MaxStall = 9'(MAX_STALL);

  ifId_t ifIdD, ifIdQ;
  idEx_t idExD, idExQ;

  logic [7:0] runCnt;
  logic [8:0] runInc;

  // PC register: StallF holds the fetch PC.
  pipe_flop_enclr #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) uPcReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~StallF),
    .clr   (1'b0),
    .d     (PCNextF),
    .q     (PCF)
  );

  // Build the IF/ID payload; a flush clears it to a NOP with ValidD=0.
  always_comb begin
    ifIdD         = '0;
    ifIdD.valid   = 1'b1;
    ifIdD.instr   = InstrF;
    ifIdD.pcPlus4 = PCPlus4F;
  end

  // IF/ID register: stall beats flush because clear is gated by enable.
  pipe_flop_enclr #(
    .WIDTH     (IfIdW),
    .RESET_VAL ({1'b0, NOP_INSTR, 32'h0})
  ) uIfIdReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~StallD),
    .clr   (FlushD),
    .d     (ifIdD),
    .q     (ifIdQ)
  );

  assign InstrD   = ifIdQ.instr;
  assign PCPlus4D = ifIdQ.pcPlus4;
  assign ValidD   = ifIdQ.valid;

  // Build the ID/EX payload from decode outputs and the D-stage valid bit.
  always_comb begin
    idExD                 = '0;
    idExD.valid           = ifIdQ.valid;
    idExD.ctrl.regWrite   = RegWriteD;
    idExD.ctrl.memtoReg   = MemtoRegD;
    idExD.ctrl.memWrite   = MemWriteD;
    idExD.ctrl.aluSrc     = ALUSrcD;
    idExD.ctrl.regDst     = RegDstD;
    idExD.ctrl.aluControl = ALUControlD;
    idExD.rd1             = RD1D;
    idExD.rd2             = RD2D;
    idExD.signImm         = SignImmD;
    idExD.rs              = RsD;
    idExD.rt              = RtD;
    idExD.rd              = RdD;
  end

  // ID/EX register: never stalls; FlushE inserts an all-zero bubble.
  pipe_flop_enclr #(
    .WIDTH     (IdExW),
    .RESET_VAL ('0)
  ) uIdExReg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (FlushE),
    .d     (idExD),
    .q     (idExQ)
  );

  assign ValidE      = idExQ.valid;
  assign RegWriteE   = idExQ.ctrl.regWrite;
  assign MemtoRegE   = idExQ.ctrl.memtoReg;
  assign MemWriteE   = idExQ.ctrl.memWrite;
  assign ALUSrcE     = idExQ.ctrl.aluSrc;
  assign RegDstE     = idExQ.ctrl.regDst;
  assign ALUControlE = idExQ.ctrl.aluControl;
  assign RD1E        = idExQ.rd1;
  assign RD2E        = idExQ.rd2;
  assign SignImmE    = idExQ.signImm;
  assign RsE         = idExQ.rs;
  assign RtE         = idExQ.rt;
  assign RdE         = idExQ.rd;

  // Stall counter: saturating, clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (CntClr) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

  // Bubble counter: same rule, counting FlushE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BubbleCount <= '0;
    end else if (CntClr) begin
      BubbleCount <= '0;
    end else if (FlushE && (BubbleCount != '1)) begin
      BubbleCount <= BubbleCount + CNT_W'(1);
    end
  end

  // Value the run counter takes on this edge if StallF stays high.
  assign runInc = {1'b0, runCnt} + 9'd1;

  // Consecutive-stall run counter, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runCnt <= '0;
    end else if (!StallF) begin
      runCnt <= '0;
    end else if (runCnt != 8'hFF) begin
      runCnt <= runInc[7:0];
    end
  end

  // Sticky watchdog flag: set on the edge the run reaches MAX_STALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallTimeout <= 1'b0;
    end else if (StallF && (runInc >= MaxStall)) begin
      StallTimeout <= 1'b1;
    end
  end

endmodule
